// File: rtl/iob_ext_mem_arbiter.sv
// iob_ext_mem_arbiter: shares one synchronous external-memory port between
// the CPU instruction bus (read-only) and the CPU data bus (read/write).
// One transfer is granted per cycle. Read data is returned one cycle later
// to the requester that issued the read.
// Optional feature: define IOB_EXT_MEM_ARB_RR_EN for round-robin tie-breaking.
// Without it, ties use fixed priority and the data bus always wins.
// Handshake: a transfer happens on a cycle where valid and ready are both
// high. The requester holds addr/wdata/wstrb stable until ready, and valid
// may drop without a transfer.
module iob_ext_mem_arbiter #(
  parameter int  ADDR_W     = 15,
  parameter int  DATA_W     = 32,
  localparam int MEM_ADDR_W = ADDR_W - 2
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  rst_i,
  input  logic                  ibus_valid_i,
  input  logic [ADDR_W-1:0]     ibus_addr_i,
  output logic                  ibus_ready_o,
  output logic                  ibus_rvalid_o,
  output logic [DATA_W-1:0]     ibus_rdata_o,
  input  logic                  dbus_valid_i,
  input  logic [ADDR_W-1:0]     dbus_addr_i,
  input  logic [DATA_W-1:0]     dbus_wdata_i,
  input  logic [DATA_W/8-1:0]   dbus_wstrb_i,
  output logic                  dbus_ready_o,
  output logic                  dbus_rvalid_o,
  output logic [DATA_W-1:0]     dbus_rdata_o,
  output logic                  ext_mem_clk_o,
  output logic                  ext_mem_r_en_o,
  output logic [MEM_ADDR_W-1:0] ext_mem_r_addr_o,
  input  logic [DATA_W-1:0]     ext_mem_r_data_i,
  output logic [MEM_ADDR_W-1:0] ext_mem_w_addr_o,
  output logic [DATA_W-1:0]     ext_mem_w_data_o,
  output logic [DATA_W/8-1:0]   ext_mem_w_strb_o
);

  // prio_q = 1: the data bus wins a tie; 0: the instruction bus wins.
  logic prio_q, prio_d;
  // A read was granted and its data arrives this cycle; owner_q = 1 means dbus.
  logic pend_q, owner_q;
  logic active;
  logic grant_i, grant_d;
  logic dbus_is_write;
  logic rd_grant;
  logic unused_addr_lsbs;

  // The byte offset is irrelevant on a word-wide memory.
  assign unused_addr_lsbs = ^{ibus_addr_i[1:0], dbus_addr_i[1:0]};

  assign ext_mem_clk_o = clk_i;
  assign active        = cke_i & ~rst_i;
  assign dbus_is_write = |dbus_wstrb_i;
  assign rd_grant      = grant_i | (grant_d & ~dbus_is_write);

  // Grant decision: a lone requester wins; on a tie, prio_q decides.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (active) begin
      if (ibus_valid_i && dbus_valid_i) begin
        grant_d = prio_q;
        grant_i = ~prio_q;
      end else begin
        grant_i = ibus_valid_i;
        grant_d = dbus_valid_i;
      end
    end
  end

  // Next priority: in round-robin mode it points away from the last grant.
  always_comb begin
`ifdef IOB_EXT_MEM_ARB_RR_EN
    prio_d = prio_q;
    if (grant_i)      prio_d = 1'b1;
    else if (grant_d) prio_d = 1'b0;
`else
    prio_d = 1'b1;
`endif
  end

  // Memory-port drive and read-data return, all zero when idle or in reset.
  always_comb begin
    ibus_ready_o     = grant_i;
    dbus_ready_o     = grant_d;
    ext_mem_r_en_o   = 1'b0;
    ext_mem_r_addr_o = '0;
    ext_mem_w_addr_o = '0;
    ext_mem_w_data_o = '0;
    ext_mem_w_strb_o = '0;
    if (grant_i) begin
      ext_mem_r_en_o   = 1'b1;
      ext_mem_r_addr_o = ibus_addr_i[ADDR_W-1:2];
    end else if (grant_d) begin
      if (dbus_is_write) begin
        ext_mem_w_addr_o = dbus_addr_i[ADDR_W-1:2];
        ext_mem_w_data_o = dbus_wdata_i;
        ext_mem_w_strb_o = dbus_wstrb_i;
      end else begin
        ext_mem_r_en_o   = 1'b1;
        ext_mem_r_addr_o = dbus_addr_i[ADDR_W-1:2];
      end
    end
    ibus_rvalid_o = pend_q & active & ~owner_q;
    dbus_rvalid_o = pend_q & active & owner_q;
    ibus_rdata_o  = ibus_rvalid_o ? ext_mem_r_data_i : '0;
    dbus_rdata_o  = dbus_rvalid_o ? ext_mem_r_data_i : '0;
  end

  // Pending-read tracking and priority state; everything holds while cke_i is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q  <= 1'b0;
      owner_q <= 1'b0;
      prio_q  <= 1'b1;
    end else if (cke_i) begin
      pend_q <= rd_grant;
      if (rd_grant) owner_q <= grant_d;
      prio_q <= prio_d;
    end
  end

endmodule

// File: tb/tb_iob_ext_mem_arbiter.sv
// Directed bench for iob_ext_mem_arbiter with a sync-RAM model on the ext_mem port.
module tb_iob_ext_mem_arbiter;
  logic        clk = 1'b0;
  logic        cke_i, rst_i;
  logic        ibus_valid_i, ibus_ready_o, ibus_rvalid_o;
  logic [14:0] ibus_addr_i;
  logic [31:0] ibus_rdata_o;
  logic        dbus_valid_i, dbus_ready_o, dbus_rvalid_o;
  logic [14:0] dbus_addr_i;
  logic [31:0] dbus_wdata_i, dbus_rdata_o;
  logic [3:0]  dbus_wstrb_i;
  logic        ext_mem_clk_o, ext_mem_r_en_o;
  logic [12:0] ext_mem_r_addr_o, ext_mem_w_addr_o;
  logic [31:0] ext_mem_r_data_i = '0;
  logic [31:0] ext_mem_w_data_o;
  logic [3:0]  ext_mem_w_strb_o;

  int checks = 0;
  int errors = 0;

  // clock
  always #5 clk = ~clk;

  iob_ext_mem_arbiter dut (
    .clk_i(clk), .cke_i(cke_i), .rst_i(rst_i),
    .ibus_valid_i(ibus_valid_i), .ibus_addr_i(ibus_addr_i),
    .ibus_ready_o(ibus_ready_o), .ibus_rvalid_o(ibus_rvalid_o), .ibus_rdata_o(ibus_rdata_o),
    .dbus_valid_i(dbus_valid_i), .dbus_addr_i(dbus_addr_i), .dbus_wdata_i(dbus_wdata_i),
    .dbus_wstrb_i(dbus_wstrb_i), .dbus_ready_o(dbus_ready_o), .dbus_rvalid_o(dbus_rvalid_o),
    .dbus_rdata_o(dbus_rdata_o), .ext_mem_clk_o(ext_mem_clk_o), .ext_mem_r_en_o(ext_mem_r_en_o),
    .ext_mem_r_addr_o(ext_mem_r_addr_o), .ext_mem_r_data_i(ext_mem_r_data_i),
    .ext_mem_w_addr_o(ext_mem_w_addr_o), .ext_mem_w_data_o(ext_mem_w_data_o),
    .ext_mem_w_strb_o(ext_mem_w_strb_o)
  );

  // Sync RAM model: stored words are XORed with an address pattern so that a
  // never-written word reads back as {16'hC0DE, 3'b0, word_addr}.
  logic [31:0] mem [0:8191] = '{default: 32'h0};

  function automatic logic [31:0] pat(input logic [12:0] a);
    return {16'hC0DE, 3'b000, a};
  endfunction

  always @(posedge ext_mem_clk_o) begin
    for (int b = 0; b < 4; b++)
      if (ext_mem_w_strb_o[b])
        mem[ext_mem_w_addr_o][8*b +: 8] <= ext_mem_w_data_o[8*b +: 8] ^ pat(ext_mem_w_addr_o)[8*b +: 8];
    if (ext_mem_r_en_o)
      ext_mem_r_data_i <= mem[ext_mem_r_addr_o] ^ pat(ext_mem_r_addr_o);
  end

  logic [159:0] all_out;
  assign all_out = 160'({ibus_ready_o, ibus_rvalid_o, ibus_rdata_o, dbus_ready_o, dbus_rvalid_o,
                         dbus_rdata_o, ext_mem_r_en_o, ext_mem_r_addr_o, ext_mem_w_addr_o,
                         ext_mem_w_data_o, ext_mem_w_strb_o});

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    ibus_valid_i = 1'b0;
    dbus_valid_i = 1'b0;
    dbus_wstrb_i = 4'h0;
  endtask

  logic [31:0] bb_data [0:3];
  logic        exp_d;
  logic        prev_d;
  int          d_cnt, i_cnt;

  initial begin
    bb_data[0] = 32'h0; bb_data[1] = 32'hC0DE0000;
    bb_data[2] = 32'hC0DE0001; bb_data[3] = 32'hC0DE0002;

    // Reset held 3 cycles with both requesters asserting valid
    rst_i = 1'b1; cke_i = 1'b1;
    ibus_valid_i = 1'b1; ibus_addr_i = 15'h0000;
    dbus_valid_i = 1'b1; dbus_addr_i = 15'h0100; dbus_wdata_i = 32'h0; dbus_wstrb_i = 4'h0;
    #1;
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("reset_outputs_c%0d", c), all_out, 160'h0);
      tick();
    end
    rst_i = 1'b0;
    settle();
    check("first_grant_dbus_ready", 160'(dbus_ready_o), 160'h1);
    check("first_grant_ibus_ready", 160'(ibus_ready_o), 160'h0);
    check("first_grant_r_addr", 160'(ext_mem_r_addr_o), 160'h040);
    tick();

    // dbus write of DEADBEEF to 0x0010, overlapping the rvalid of the first read
    idle();
    dbus_valid_i = 1'b1; dbus_addr_i = 15'h0010; dbus_wdata_i = 32'hDEADBEEF; dbus_wstrb_i = 4'hF;
    settle();
    check("wr_ready", 160'(dbus_ready_o), 160'h1);
    check("wr_w_addr", 160'(ext_mem_w_addr_o), 160'h004);
    check("wr_w_strb", 160'(ext_mem_w_strb_o), 160'hF);
    check("wr_w_data", 160'(ext_mem_w_data_o), 160'hDEADBEEF);
    check("wr_r_en", 160'(ext_mem_r_en_o), 160'h0);
    check("first_rd_rvalid", 160'(dbus_rvalid_o), 160'h1);
    check("first_rd_rdata", 160'(dbus_rdata_o), 160'hC0DE0040);
    tick();

    // ibus read of the word just written
    idle();
    ibus_valid_i = 1'b1; ibus_addr_i = 15'h0010;
    settle();
    check("ird_ready", 160'(ibus_ready_o), 160'h1);
    check("ird_r_addr", 160'(ext_mem_r_addr_o), 160'h004);
    check("wr_no_rvalid", 160'(dbus_rvalid_o), 160'h0);
    tick();
    idle();
    settle();
    check("ird_rvalid", 160'(ibus_rvalid_o), 160'h1);
    check("ird_rdata", 160'(ibus_rdata_o), 160'hDEADBEEF);
    check("ird_nonowner_rdata", 160'(dbus_rdata_o), 160'h0);
    tick();

    // Simultaneous reads for 4 cycles: ibus 0x0000, dbus 0x0100
    d_cnt = 0; i_cnt = 0; prev_d = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ibus_valid_i = 1'b1; ibus_addr_i = 15'h0000;
      dbus_valid_i = 1'b1; dbus_addr_i = 15'h0100; dbus_wstrb_i = 4'h0;
`ifdef IOB_EXT_MEM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      settle();
      check($sformatf("sim_dready_k%0d", k), 160'(dbus_ready_o), 160'(exp_d));
      check($sformatf("sim_iready_k%0d", k), 160'(ibus_ready_o), 160'(!exp_d));
      check($sformatf("sim_r_addr_k%0d", k), 160'(ext_mem_r_addr_o), exp_d ? 160'h040 : 160'h000);
      if (k == 0) begin
        check("sim_no_rvalid_k0", 160'({ibus_rvalid_o, dbus_rvalid_o}), 160'h0);
      end else begin
        check($sformatf("sim_rvalid_k%0d", k), 160'({ibus_rvalid_o, dbus_rvalid_o}), prev_d ? 160'h1 : 160'h2);
        check($sformatf("sim_rdata_k%0d", k), 160'(prev_d ? dbus_rdata_o : ibus_rdata_o),
              prev_d ? 160'hC0DE0040 : 160'hC0DE0000);
      end
      if (dbus_ready_o) d_cnt++;
      if (ibus_ready_o) i_cnt++;
      prev_d = exp_d;
      tick();
    end
    idle();
    settle();
    check("sim_last_rvalid", 160'({ibus_rvalid_o, dbus_rvalid_o}), prev_d ? 160'h1 : 160'h2);
`ifdef IOB_EXT_MEM_ARB_RR_EN
    check("sim_dbus_grants", 160'(d_cnt), 160'd2);
    check("sim_ibus_grants", 160'(i_cnt), 160'd2);
`else
    check("sim_dbus_grants", 160'(d_cnt), 160'd4);
    check("sim_ibus_grants", 160'(i_cnt), 160'd0);
`endif
    tick();

    // Back-to-back ibus reads 0x0, 0x4, 0x8
    for (int k = 0; k < 4; k++) begin
      idle();
      if (k < 3) begin
        ibus_valid_i = 1'b1; ibus_addr_i = 15'(4 * k);
      end
      settle();
      check($sformatf("b2b_ready_k%0d", k), 160'(ibus_ready_o), 160'(k < 3));
      check($sformatf("b2b_rvalid_k%0d", k), 160'(ibus_rvalid_o), 160'(k > 0));
      check($sformatf("b2b_rdata_k%0d", k), 160'(ibus_rdata_o), 160'(bb_data[k]));
      tick();
    end

    // Read accepted, then reset on the next cycle
    idle();
    dbus_valid_i = 1'b1; dbus_addr_i = 15'h0100;
    settle();
    check("rstmid_ready", 160'(dbus_ready_o), 160'h1);
    tick();
    idle();
    rst_i = 1'b1;
    settle();
    check("rstmid_rvalid_in_rst", 160'({ibus_rvalid_o, dbus_rvalid_o}), 160'h0);
    tick();
    rst_i = 1'b0;
    settle();
    check("rstmid_rvalid_after", 160'({ibus_rvalid_o, dbus_rvalid_o}), 160'h0);
    check("rstmid_owner_q", 160'(dut.owner_q), 160'h0);
    tick();
    settle();
    check("rstmid_rvalid_later", 160'({ibus_rvalid_o, dbus_rvalid_o}), 160'h0);
    tick();

    // cke_i low for 2 cycles right after a dbus read grant
    dbus_valid_i = 1'b1; dbus_addr_i = 15'h0004;
    settle();
    check("cke_grant", 160'(dbus_ready_o), 160'h1);
    tick();
    cke_i = 1'b0;
    dbus_addr_i = 15'h0008; ibus_valid_i = 1'b1; ibus_addr_i = 15'h000C;
    for (int c = 0; c < 2; c++) begin
      settle();
      check($sformatf("cke_stall_grants_c%0d", c), 160'({ibus_ready_o, dbus_ready_o, ext_mem_r_en_o}), 160'h0);
      check($sformatf("cke_stall_rvalid_c%0d", c), 160'({ibus_rvalid_o, dbus_rvalid_o}), 160'h0);
      tick();
    end
    cke_i = 1'b1;
    idle();
    settle();
    check("cke_resume_rvalid", 160'(dbus_rvalid_o), 160'h1);
    check("cke_resume_rdata", 160'(dbus_rdata_o), 160'hC0DE0001);
    tick();

    // Partial-strobe write, then read with nonzero byte offset
    dbus_valid_i = 1'b1; dbus_addr_i = 15'h0010; dbus_wdata_i = 32'h11223344; dbus_wstrb_i = 4'h3;
    settle();
    check("pwr_w_strb", 160'(ext_mem_w_strb_o), 160'h3);
    tick();
    dbus_wstrb_i = 4'h0; dbus_addr_i = 15'h0013;
    settle();
    check("pwr_rd_r_addr", 160'(ext_mem_r_addr_o), 160'h004);
    tick();
    idle();
    settle();
    check("pwr_rd_rdata", 160'(dbus_rdata_o), 160'hDEAD3344);
    check("pwr_rd_ibus_rdata", 160'(ibus_rdata_o), 160'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
